// File: rtl/ex_hilo_unit.sv
// EX-stage HI/LO unit: single-cycle MULT/MULTU, 32-step restoring DIV/DIVU,
// MTHI/MTLO, and MFHI/MFLO with MEM/WB forwarding.
module ex_hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op_i,
    input  logic [31:0] opA_i,
    input  logic [31:0] opB_i,
    input  logic        flush_i,
    input  logic [31:0] hi_reg_i,
    input  logic [31:0] lo_reg_i,
    input  logic [1:0]  mem_writeHILO_i,
    input  logic [31:0] mem_HI_i,
    input  logic [31:0] mem_LO_i,
    input  logic [1:0]  wb_writeHILO_i,
    input  logic [31:0] wb_HI_i,
    input  logic [31:0] wb_LO_i,
    output logic [31:0] HI_data_o,
    output logic [31:0] LO_data_o,
    output logic [1:0]  writeHILO_o,
    output logic [31:0] mf_result_o,
    output logic        stallreq_o
);

    localparam int unsigned W          = 32;
    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned CNT_W      = 5;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [W-1:0]       quo;
    logic [W-1:0]       rem;
    logic [W-1:0]       dsr;
    logic [CNT_W-1:0]   count;
    logic               neg_q;
    logic               neg_r;

    logic               is_div;
    logic               is_sdiv;
    logic [W-1:0]       abs_a;
    logic [W-1:0]       abs_b;
    logic [2*W-1:0]     prod_s;
    logic [2*W-1:0]     prod_u;
    logic [W:0]         shifted;
    logic [W:0]         diff;
    logic [W-1:0]       rem_nxt;
    logic [W-1:0]       quo_nxt;
    logic               last_step;

    assign is_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign is_sdiv   = (op_i == OP_DIV);
    assign abs_a     = (is_sdiv && opA_i[W-1]) ? -opA_i : opA_i;
    assign abs_b     = (is_sdiv && opB_i[W-1]) ? -opB_i : opB_i;
    assign last_step = (count == CNT_W'(DIV_CYCLES - 1));

    // Low 64 bits of the sign-extended product equal the signed product.
    assign prod_s = {{W{opA_i[W-1]}}, opA_i} * {{W{opB_i[W-1]}}, opB_i};
    assign prod_u = {{W{1'b0}}, opA_i} * {{W{1'b0}}, opB_i};

    // One restoring step: partial remainder stays below divisor, so 33 bits suffice.
    assign shifted = {rem, quo[W-1]};
    assign diff    = shifted - {1'b0, dsr};
    assign rem_nxt = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    assign quo_nxt = {quo[W-2:0], ~diff[W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            quo   <= '0;
            rem   <= '0;
            dsr   <= '0;
            count <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_div) begin
                        if (opB_i == '0) begin
                            quo   <= '1;
                            rem   <= opA_i;
                            state <= DONE;
                        end else begin
                            quo   <= abs_a;
                            rem   <= '0;
                            dsr   <= abs_b;
                            count <= '0;
                            neg_q <= is_sdiv && (opA_i[W-1] ^ opB_i[W-1]);
                            neg_r <= is_sdiv && opA_i[W-1];
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    count <= count + CNT_W'(1);
                    if (last_step) begin
                        // Sign fix-up folded into the final step so DONE just presents.
                        quo   <= neg_q ? -quo_nxt : quo_nxt;
                        rem   <= neg_r ? -rem_nxt : rem_nxt;
                        state <= DONE;
                    end else begin
                        quo <= quo_nxt;
                        rem <= rem_nxt;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        HI_data_o   = '0;
        LO_data_o   = '0;
        writeHILO_o = 2'b00;
        mf_result_o = '0;
        stallreq_o  = 1'b0;
        if (!rst && !flush_i) begin
            unique case (state)
                IDLE: begin
                    unique case (op_i)
                        OP_MULT: begin
                            HI_data_o   = prod_s[2*W-1:W];
                            LO_data_o   = prod_s[W-1:0];
                            writeHILO_o = 2'b11;
                        end
                        OP_MULTU: begin
                            HI_data_o   = prod_u[2*W-1:W];
                            LO_data_o   = prod_u[W-1:0];
                            writeHILO_o = 2'b11;
                        end
                        OP_DIV, OP_DIVU: stallreq_o = 1'b1;
                        OP_MTHI: begin
                            HI_data_o   = opA_i;
                            writeHILO_o = 2'b10;
                        end
                        OP_MTLO: begin
                            LO_data_o   = opA_i;
                            writeHILO_o = 2'b01;
                        end
                        OP_MFHI: begin
                            if (mem_writeHILO_i[1])     mf_result_o = mem_HI_i;
                            else if (wb_writeHILO_i[1]) mf_result_o = wb_HI_i;
                            else                        mf_result_o = hi_reg_i;
                        end
                        OP_MFLO: begin
                            if (mem_writeHILO_i[0])     mf_result_o = mem_LO_i;
                            else if (wb_writeHILO_i[0]) mf_result_o = wb_LO_i;
                            else                        mf_result_o = lo_reg_i;
                        end
                        default: ;
                    endcase
                end
                BUSY: stallreq_o = 1'b1;
                DONE: begin
                    HI_data_o   = rem;
                    LO_data_o   = quo;
                    writeHILO_o = 2'b11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_hilo_unit.sv
// Directed self-checking bench for ex_hilo_unit with hand-computed expectations.
module tb_ex_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  op;
    logic [31:0] opa, opb;
    logic        flush;
    logic [31:0] hi_reg, lo_reg;
    logic [1:0]  mem_wr, wb_wr;
    logic [31:0] mem_hi, mem_lo, wb_hi, wb_lo;
    logic [31:0] hi_data, lo_data, mf_result;
    logic [1:0]  write_hilo;
    logic        stallreq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_hilo_unit dut (
        .clk             (clk),
        .rst             (rst),
        .op_i            (op),
        .opA_i           (opa),
        .opB_i           (opb),
        .flush_i         (flush),
        .hi_reg_i        (hi_reg),
        .lo_reg_i        (lo_reg),
        .mem_writeHILO_i (mem_wr),
        .mem_HI_i        (mem_hi),
        .mem_LO_i        (mem_lo),
        .wb_writeHILO_i  (wb_wr),
        .wb_HI_i         (wb_hi),
        .wb_LO_i         (wb_lo),
        .HI_data_o       (hi_data),
        .LO_data_o       (lo_data),
        .writeHILO_o     (write_hilo),
        .mf_result_o     (mf_result),
        .stallreq_o      (stallreq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_hi"},    hi_data, 32'h0);
        check({tag, "_lo"},    lo_data, 32'h0);
        check({tag, "_wr"},    32'(write_hilo), 32'h0);
        check({tag, "_stall"}, 32'(stallreq), 32'h0);
    endtask

    // Issues a divide, holds it while stalled, checks stall length and result.
    task automatic run_div(input string tag, input logic [3:0] dop, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stall,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int n;
        op  = dop;
        opa = a;
        opb = b;
        #1;
        n = 0;
        while (stallreq === 1'b1 && n < 40) begin
            n++;
            next_cycle();
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        check({tag, "_lo"}, lo_data, exp_lo);
        check({tag, "_hi"}, hi_data, exp_hi);
        check({tag, "_wr"}, 32'(write_hilo), 32'h3);
        op = 4'd0;
        next_cycle();
        check_idle_outputs({tag, "_after"});
    endtask

    initial begin
        rst = 1'b1; op = 4'd0; opa = '0; opb = '0; flush = 1'b0;
        hi_reg = '0; lo_reg = '0; mem_wr = 2'b00; wb_wr = 2'b00;
        mem_hi = '0; mem_lo = '0; wb_hi = '0; wb_lo = '0;

        op = 4'd1; opa = 32'hFFFF_FFFF; opb = 32'd2;
        #3;
        check_idle_outputs("reset");
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        check("mult_hi", hi_data, 32'hFFFF_FFFF);
        check("mult_lo", lo_data, 32'hFFFF_FFFE);
        check("mult_wr", 32'(write_hilo), 32'h3);
        check("mult_stall", 32'(stallreq), 32'h0);

        op = 4'd2; #1;
        check("multu_hi", hi_data, 32'h0000_0001);
        check("multu_lo", lo_data, 32'hFFFF_FFFE);

        op = 4'd1; opa = 32'h0001_2345; opb = 32'h0000_1000; #1;
        check("mult_pos_hi", hi_data, 32'h0000_0000);
        check("mult_pos_lo", lo_data, 32'h1234_5000);

        op = 4'd5; opa = 32'hCAFE_0001; #1;
        check("mthi_hi", hi_data, 32'hCAFE_0001);
        check("mthi_wr", 32'(write_hilo), 32'h2);
        op = 4'd6; #1;
        check("mtlo_lo", lo_data, 32'hCAFE_0001);
        check("mtlo_wr", 32'(write_hilo), 32'h1);

        mem_hi = 32'hAAAA_AAAA; wb_hi = 32'hBBBB_BBBB; hi_reg = 32'hCCCC_CCCC;
        mem_lo = 32'h1111_1111; wb_lo = 32'h2222_2222; lo_reg = 32'h3333_3333;
        op = 4'd7; mem_wr = 2'b10; wb_wr = 2'b10; #1;
        check("mfhi_mem", mf_result, 32'hAAAA_AAAA);
        check("mfhi_wr", 32'(write_hilo), 32'h0);
        mem_wr = 2'b00; #1;
        check("mfhi_wb", mf_result, 32'hBBBB_BBBB);
        wb_wr = 2'b00; #1;
        check("mfhi_reg", mf_result, 32'hCCCC_CCCC);
        op = 4'd8; mem_wr = 2'b10; #1;
        check("mflo_reg", mf_result, 32'h3333_3333);
        wb_wr = 2'b01; #1;
        check("mflo_wb", mf_result, 32'h2222_2222);
        mem_wr = 2'b00; wb_wr = 2'b00;
        op = 4'd0;
        next_cycle();

        run_div("divu_100_7", 4'd4, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        run_div("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_min_m1", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0);
        run_div("divu_5_0", 4'd4, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5);
        run_div("div_7_m3", 4'd3, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFE, 32'd1);
        run_div("divu_big", 4'd4, 32'hFFFF_FFFF, 32'h0001_0000, 33, 32'h0000_FFFF, 32'h0000_FFFF);

        // Flush in cycle 10 of a divide.
        op = 4'd4; opa = 32'd100; opb = 32'd7;
        #1;
        check("flush_c0_stall", 32'(stallreq), 32'h1);
        for (int c = 1; c < 10; c++) next_cycle();
        check("flush_c9_stall", 32'(stallreq), 32'h1);
        next_cycle();
        flush = 1'b1; #1;
        check_idle_outputs("flush_c10");
        next_cycle();
        flush = 1'b0; op = 4'd0; #1;
        check_idle_outputs("flush_c11");
        op = 4'd5; opa = 32'h0000_0042; #1;
        check("flush_idle_mthi", hi_data, 32'h0000_0042);
        check("flush_idle_wr", 32'(write_hilo), 32'h2);
        op = 4'd0;
        next_cycle();

        // Asynchronous reset mid-cycle during a divide.
        op = 4'd3; opa = 32'd1000; opb = 32'd3;
        #1;
        for (int c = 1; c < 6; c++) next_cycle();
        check("rst_pre_stall", 32'(stallreq), 32'h1);
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        next_cycle();
        op = 4'd0;
        rst = 1'b0;
        #1;
        check_idle_outputs("rst_after");
        next_cycle();
        run_div("div_after_rst", 4'd3, 32'd1000, 32'd3, 33, 32'd333, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
